// File: rtl/serial_adder_controller.sv
// Bit-serial adder sequencer: one full-adder slice, LSB first, valid/ack result.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input that computes a-b instead.

module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;
    logic g;
    logic t;

    assign p   = a_i ^ b_i;
    assign g   = a_i & b_i;
    assign t   = p & c_i;
    assign s_o = p ^ c_i;
    assign c_o = g | t;
endmodule

module serial_adder_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             ack,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    serial_adder_fa u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // New sum bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts
    if (WIDTH == 1) begin : g_sum1
        assign sum_next = fa_s;
    end else begin : g_sumn
        assign sum_next = {fa_s, sum_sh_q[WIDTH-1:1]};
    end

`ifdef SERIAL_ADD_SUB_EN
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub | carryin;
`else
    assign b_load   = b;
    assign cin_load = carryin;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (count_q == LAST) state_d = S_DONE;
            S_DONE: if (ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = cin_load;
                    count_d = '0;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_next;
                carry_d  = fa_c;
                count_d  = count_q + ONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        ready    = (state_q == S_IDLE);
        busy     = (state_q == S_RUN);
        valid    = (state_q == S_DONE);
        sum      = sum_sh_q;
        carryout = carry_q;
    end
endmodule

// File: tb/tb_serial_adder_controller.sv
// Randomized self-checking bench for serial_adder_controller (WIDTH=8 and WIDTH=1).
// Reference results come from plain integer add/subtract of the operands.

module tb_serial_adder_controller;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, ack, carryin;
    logic [7:0] a, b;
    logic       ready, busy, valid, carryout;
    logic [7:0] sum;

    logic       start1, ack1, cin1;
    logic [0:0] a1, b1;
    logic       ready1, busy1, valid1, cout1;
    logic [0:0] sum1;

`ifdef SERIAL_ADD_SUB_EN
    logic sub, sub1;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #100 clk = ~clk;

    serial_adder_controller #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .ack      (ack),
        .ready    (ready),
        .busy     (busy),
        .valid    (valid),
        .sum      (sum),
        .carryout (carryout)
    );

    serial_adder_controller #(.WIDTH(1)) dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start1),
        .a        (a1),
        .b        (b1),
        .carryin  (cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub1),
`endif
        .ack      (ack1),
        .ready    (ready1),
        .busy     (busy1),
        .valid    (valid1),
        .sum      (sum1),
        .carryout (cout1)
    );

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic sb);
        int r;
        if (sb) begin
            r = int'(x) - int'(y);
            return {(x >= y), r[7:0]};
        end
        r = int'(x) + int'(y) + int'(ci);
        return r[8:0];
    endfunction

    task automatic run_add8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                            input logic sb, output logic [7:0] s, output logic co,
                            output int lat);
        @(negedge clk);
        start = 1'b1; a = x; b = y; carryin = ci;
`ifdef SERIAL_ADD_SUB_EN
        sub = sb;
`else
        if (sb) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); carryin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'($urandom);
`endif
        lat = 0;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        s = sum;
        co = carryout;
    endtask

    task automatic do_ack;
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset;
        #50;
        vectors++;
        if ({ready, busy, valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 100", {ready, busy, valid});
        end
        vectors++;
        if ({carryout, sum} !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_data got %h exp 000", {carryout, sum});
        end
        vectors++;
        if ({ready1, busy1, valid1, cout1, sum1} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_w1 got %b exp 10000",
                     {ready1, busy1, valid1, cout1, sum1});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] s;
        logic co;
        int lat;
        run_add8(8'h35, 8'h4A, 1'b0, 1'b0, s, co, lat);
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL basic_latency got %0d exp 8", lat);
        end
        vectors++;
        if ({co, s} !== 9'h07F) begin
            miscompares++;
            $display("FAIL basic_sum got %h exp 07f", {co, s});
        end
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if ({ready, busy, valid, carryout, sum} !== {3'b001, co, s}) begin
                miscompares++;
                $display("FAIL basic_hold got %b/%h exp 001/%h",
                         {ready, busy, valid}, {carryout, sum}, {co, s});
            end
        end
        do_ack();
        vectors++;
        if ({ready, busy, valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_ack got %b exp 100", {ready, busy, valid});
        end
    endtask

    task automatic test_directed;
        logic [7:0] xs [2] = '{8'hFF, 8'hFF};
        logic [7:0] ys [2] = '{8'h01, 8'hFF};
        logic       cs [2] = '{1'b0, 1'b1};
        logic [8:0] ex [2] = '{9'h100, 9'h1FF};
        logic [7:0] s;
        logic co;
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_add8(xs[i], ys[i], cs[i], 1'b0, s, co, lat);
            vectors++;
            if ({co, s} !== ex[i] || lat != 8) begin
                miscompares++;
                $display("FAIL directed_%0d got %h lat %0d exp %h lat 8",
                         i, {co, s}, lat, ex[i]);
            end
            do_ack();
        end
    endtask

    task automatic test_ignore_inputs;
        int lat;
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; carryin = 1'b0;
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00; carryin = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if ({carryout, sum} !== 9'h046 || lat != 8) begin
            miscompares++;
            $display("FAIL ignore_sum got %h lat %0d exp 046 lat 8", {carryout, sum}, lat);
        end
        do_ack();
        repeat (2) @(negedge clk);
        vectors++;
        if ({ready, busy, valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL ignore_no_second got %b exp 100", {ready, busy, valid});
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] s;
        logic co;
        int lat;
        @(negedge clk);
        start = 1'b1; a = 8'hA5; b = 8'h3C; carryin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #20;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({ready, busy, valid, carryout, sum} !== 12'b100_0_0000_0000) begin
            miscompares++;
            $display("FAIL midreset_async got %b/%h exp 100/000",
                     {ready, busy, valid}, {carryout, sum});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_add8(8'h01, 8'h01, 1'b0, 1'b0, s, co, lat);
        vectors++;
        if ({co, s} !== 9'h002 || lat != 8) begin
            miscompares++;
            $display("FAIL midreset_after got %h lat %0d exp 002 lat 8", {co, s}, lat);
        end
        do_ack();
    endtask

    task automatic test_width1;
        int lat;
        int e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start1 = 1'b1; a1 = 1'(i); b1 = 1'(i >> 1); cin1 = 1'(i >> 2);
            e = (i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1);
            @(negedge clk);
            start1 = 1'b0;
            lat = 0;
            while (!valid1 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            vectors++;
            if ({cout1, sum1} !== 2'(e) || lat != 1) begin
                miscompares++;
                $display("FAIL w1_add_%0d got %b lat %0d exp %b lat 1",
                         i, {cout1, sum1}, lat, 2'(e));
            end
            start1 = (i == 7);
            ack1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            ack1 = 1'b0;
            vectors++;
            if ({ready1, busy1, valid1} !== 3'b100) begin
                miscompares++;
                $display("FAIL w1_ack_%0d got %b exp 100", i, {ready1, busy1, valid1});
            end
        end
        @(negedge clk);
        vectors++;
        if ({ready1, busy1, valid1} !== 3'b100) begin
            miscompares++;
            $display("FAIL w1_start_ack got %b exp 100", {ready1, busy1, valid1});
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [8:0] e;
        @(negedge clk);
        a = 8'h9C; b = 8'h77; carryin = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        start = 1'b1;
        e = model(8'h9C, 8'h77, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            lat = 0;
            while (!valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            vectors++;
            if ({carryout, sum} !== e) begin
                miscompares++;
                $display("FAIL b2b_sum_%0d got %h exp %h", k, {carryout, sum}, e);
            end
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            vectors++;
            if ({ready, busy, valid} !== 3'b100) begin
                miscompares++;
                $display("FAIL b2b_idle_%0d got %b exp 100", k, {ready, busy, valid});
            end
            if (k == 1) start = 1'b0;
            @(negedge clk);
            vectors++;
            if ({ready, busy, valid} !== ((k == 0) ? 3'b010 : 3'b100)) begin
                miscompares++;
                $display("FAIL b2b_restart_%0d got %b", k, {ready, busy, valid});
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] x, y, s;
        logic ci, sb, co;
        logic [8:0] e;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            e = model(x, y, ci, sb);
            run_add8(x, y, ci, sb, s, co, lat);
            vectors++;
            if ({co, s} !== e || lat != 8) begin
                miscompares++;
                $display("FAIL random_%0d %h %h %b sub %b got %h lat %0d exp %h",
                         i, x, y, ci, sb, {co, s}, lat, e);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            vectors++;
            if ({valid, carryout, sum} !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL random_hold_%0d got %b/%h exp 1/%h",
                         i, valid, {carryout, sum}, e);
            end
            do_ack();
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub;
        logic [7:0] s;
        logic co;
        int lat;
        run_add8(8'h10, 8'h01, 1'b0, 1'b1, s, co, lat);
        vectors++;
        if ({co, s} !== 9'h10F) begin
            miscompares++;
            $display("FAIL sub_10_01 got %h exp 10f", {co, s});
        end
        do_ack();
        run_add8(8'h01, 8'h02, 1'b1, 1'b1, s, co, lat);
        vectors++;
        if ({co, s} !== 9'h0FF) begin
            miscompares++;
            $display("FAIL sub_01_02 got %h exp 0ff", {co, s});
        end
        do_ack();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        start = 1'b0; ack = 1'b0; carryin = 1'b0; a = '0; b = '0;
        start1 = 1'b0; ack1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0; sub1 = 1'b0;
`endif
        test_reset();
        test_basic();
        test_directed();
        test_ignore_inputs();
        test_mid_reset();
        test_width1();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
